// File: rtl/lfsr8_checker.sv
// lfsr8_checker: receive-side checker for the 8-bit LFSR pattern generator.
// Self-synchronises to the incoming serial stream (HUNT -> SYNC -> LOCKED),
// then runs a flywheel copy of the LFSR and flags every mismatching bit.
// Outputs: lock status, per-bit error pulse, saturating error count and a
// once-per-period marker.
// Optional: define LFSR8_CHECKER_BITCOUNT_EN to build the 16-bit count of
// samples taken while locked (BER denominator); otherwise o_bit_count is 0.
module lfsr8_checker #(
    parameter logic [7:0] TAPS   = 8'hB8,
    parameter int         LOCK_N = 16,
    parameter int         LOSS_N = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_din,
    input  logic        i_clear,
    output logic        o_locked,
    output logic        o_err,
    output logic [7:0]  o_err_count,
    output logic        o_period,
    output logic [15:0] o_bit_count
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_N);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_N);

    state_t     r_state, w_state_next;
    logic [7:0] r_s, w_s_next;
    logic [3:0] r_fill, w_fill_next;
    logic [7:0] r_match, w_match_next;
    logic [3:0] r_bad, w_bad_next;

    logic       r_locked, w_locked_next;
    logic       r_err, w_err_next;
    logic       r_period, w_period_next;
    logic [7:0] r_err_count, w_err_count_next;

    logic       w_expected;
    logic       w_mismatch;
    logic       w_s_zero;
    logic       w_hit;
    logic [7:0] w_match_inc;
    logic [3:0] w_bad_inc;

    // Prediction of the next bit is the parity of the tapped history bits.
    assign w_expected  = ^(r_s & TAPS);
    assign w_mismatch  = (i_din != w_expected);
    assign w_s_zero    = (r_s == 8'h00);
    assign w_match_inc = r_match + 8'd1;
    assign w_bad_inc   = r_bad + 4'd1;
    // A counted error: a consumed sample that disagrees while locked.
    assign w_hit       = i_en && (r_state == ST_LOCKED) && w_mismatch;

    // State, history and all registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_HUNT;
            r_s         <= 8'h00;
            r_fill      <= 4'd0;
            r_match     <= 8'd0;
            r_bad       <= 4'd0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_period    <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_s         <= w_s_next;
            r_fill      <= w_fill_next;
            r_match     <= w_match_next;
            r_bad       <= w_bad_next;
            r_locked    <= w_locked_next;
            r_err       <= w_err_next;
            r_period    <= w_period_next;
            r_err_count <= w_err_count_next;
        end
    end

    // Next-state and history update; nothing moves unless a sample is consumed.
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_fill_next  = r_fill;
        w_match_next = r_match;
        w_bad_next   = r_bad;
        if (i_en) begin
            case (r_state)
                ST_HUNT: begin
                    w_s_next    = {r_s[6:0], i_din};
                    w_fill_next = r_fill + 4'd1;
                    if (r_fill == 4'd7) begin
                        w_state_next = ST_SYNC;
                        w_match_next = 8'd0;
                    end
                end
                ST_SYNC: begin
                    w_s_next = {r_s[6:0], i_din};
                    if (w_mismatch) begin
                        w_state_next = ST_HUNT;
                        w_fill_next  = 4'd0;
                    end else if (w_s_zero) begin
                        // An all-zero history trivially predicts zero; never lock on it.
                        w_match_next = 8'd0;
                    end else begin
                        w_match_next = w_match_inc;
                        if (w_match_inc == LOCK_LAST) begin
                            w_state_next = ST_LOCKED;
                            w_bad_next   = 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: feed back the prediction so one flipped bit is
                    // not re-seen through the history on later samples.
                    w_s_next = {r_s[6:0], w_expected};
                    if (w_mismatch) begin
                        w_bad_next = w_bad_inc;
                        if (w_bad_inc == LOSS_LAST) begin
                            w_state_next = ST_HUNT;
                            w_fill_next  = 4'd0;
                        end
                    end else begin
                        w_bad_next = 4'd0;
                    end
                end
                default: begin
                    w_state_next = ST_HUNT;
                    w_fill_next  = 4'd0;
                end
            endcase
        end
    end

    // Next values of the status outputs.
    always_comb begin
        w_locked_next    = (w_state_next == ST_LOCKED);
        w_err_next       = w_hit;
        w_period_next    = i_en && (r_state == ST_LOCKED) && (w_s_next == 8'hFF);
        w_err_count_next = r_err_count;
        if (i_clear) begin
            // A clear coinciding with an error keeps that error.
            w_err_count_next = {7'd0, w_hit};
        end else if (w_hit && (r_err_count != 8'hFF)) begin
            w_err_count_next = r_err_count + 8'd1;
        end
    end

    assign o_locked    = r_locked;
    assign o_err       = r_err;
    assign o_period    = r_period;
    assign o_err_count = r_err_count;

`ifdef LFSR8_CHECKER_BITCOUNT_EN
    logic [15:0] r_bit_count, w_bit_count_next;

    // Samples consumed while locked, saturating; clear takes priority.
    always_comb begin
        w_bit_count_next = r_bit_count;
        if (i_clear) begin
            w_bit_count_next = 16'h0000;
        end else if (i_en && (r_state == ST_LOCKED) && (r_bit_count != 16'hFFFF)) begin
            w_bit_count_next = r_bit_count + 16'd1;
        end
    end

    // Locked-sample counter register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bit_count <= 16'h0000;
        end else begin
            r_bit_count <= w_bit_count_next;
        end
    end

    assign o_bit_count = r_bit_count;
`else
    assign o_bit_count = 16'h0000;
`endif

endmodule

// File: doc/lfsr8_checker.md
Name: lfsr8_checker

Overview:
- Receive-side counterpart of the on-chip 8-bit LFSR pattern generator.
- Samples the serial stream leaving the SISO chain (D_OUT path), self-synchronises to the LFSR sequence and checks every bit.
- Reports lock status, per-bit error pulses, a saturating error count and a once-per-period marker.
- Sits on the CLK_OUT domain beside the generator; used for on-silicon BER measurement of the SISO.

Parameters:
- TAPS, 8'hB8, feedback mask over history register S[7:0]; default gives expected = S[7]^S[5]^S[4]^S[3] (primitive, period 255).
- LOCK_N, 16, consecutive matches in SYNC required to declare lock (1..255).
- LOSS_N, 4, consecutive mismatches in LOCKED that drop lock (1..15).

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high; clears all state.
- EN  in  1  sample strobe; DIN is consumed only on edges where EN=1.
- DIN  in  1  received serial bit.
- CLEAR  in  1  synchronous clear of ERR_COUNT (and BIT_COUNT).
- LOCKED  out  1  high while in LOCKED state.
- ERR  out  1  one-cycle pulse per mismatched bit while LOCKED.
- ERR_COUNT  out  8  saturating count of LOCKED mismatches.
- PERIOD  out  1  one-cycle pulse when the flywheel register equals 8'hFF while LOCKED.
- BIT_COUNT  out  16  see Optional Feature.

Behaviour:
- Reset values: S=0, state=HUNT, fill/match/bad counters=0, LOCKED=0, ERR=0, ERR_COUNT=0, PERIOD=0, BIT_COUNT=0. RESET asserted mid-operation returns to this state immediately (asynchronous).
- S[0] is the newest bit; S[k] is the bit from k+1 samples ago. Shift occurs only on EN=1.
- expected = XOR of (S & TAPS).
- All outputs are registered and update on the edge that consumes the sample; no change when EN=0, except ERR and PERIOD, which return to 0.
- HUNT:
  - Shift DIN into S and increment fill.
  - On the 8th sample, go to SYNC with match=0.
- SYNC:
  - Shift DIN into S.
  - If DIN==expected and S!=0: match++. When match reaches LOCK_N, go to LOCKED on the same edge (bad=0).
  - If S==0: match=0, stay in SYNC. This guard prevents false lock on an all-zero stream.
  - If DIN!=expected: fill=0, go to HUNT. No ERR and no count.
- LOCKED (flywheel):
  - Shift *expected*, not DIN, into S, so a single flipped bit is counted exactly once.
  - On DIN!=expected: ERR=1, ERR_COUNT=min(ERR_COUNT+1,255), bad++. When bad reaches LOSS_N: go to HUNT, fill=0, LOCKED=0 on the same edge.
  - On a match: bad=0.
  - PERIOD=1 when the post-shift S==8'hFF.
- Errors are counted only in LOCKED. HUNT and SYNC never assert ERR.
- CLEAR and a counted error on the same edge: ERR_COUNT=1. CLEAR alone: ERR_COUNT=0. CLEAR does not affect state or lock.
- ERR_COUNT holds at 255 until CLEAR or RESET.

Optional Feature:
- Macro LFSR8_CHECKER_BITCOUNT_EN.
- Defined: BIT_COUNT counts EN samples taken while LOCKED, saturating at 16'hFFFF; cleared by CLEAR (CLEAR wins over increment, then counts from 0 next sample) and by RESET. Provides the BER denominator.
- Undefined: no counter logic; BIT_COUNT tied to 16'h0000.

Test Plan:
- Stream a clean LFSR sequence (seed S=8'h01), EN every cycle -> LOCKED rises on the 24th EN sample (8 fill + 16 matches); ERR never pulses; ERR_COUNT=0; PERIOD pulses exactly every 255 EN samples.
- While locked, flip one DIN bit -> exactly one ERR pulse, ERR_COUNT=1, LOCKED stays 1; next 255 bits clean -> no further ERR.
- While locked, invert 4 consecutive bits -> ERR_COUNT=4, LOCKED falls on the 4th bad sample; resume the clean stream -> LOCKED returns after 24 further EN samples.
- DIN held at 0 for 1000 samples from reset -> LOCKED stays 0, ERR_COUNT=0. EN gated at 50% duty with a clean stream -> same lock latency in EN samples as the first scenario.
- Random DIN while locked with LOSS_N set to 15, injecting 300 isolated errors -> ERR_COUNT saturates at 255; CLEAR coincident with an error -> ERR_COUNT=1.
- Assert RESET asynchronously mid-LOCKED (between edges) -> LOCKED, ERR_COUNT, BIT_COUNT are 0 immediately. With the macro defined: 1000 locked samples -> BIT_COUNT=1000.
